// File: rtl/jt1943_objdma.sv
// jt1943_objdma: per-frame object table DMA from main work RAM into a double-buffered object store.
module jt1943_objdma #(
    parameter int          AW       = 9,
    parameter logic [12:0] OBJ_BASE = 13'h1000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          LVBL,
    input  logic          OKOUT,
    input  logic          bus_ack,
    input  logic [7:0]    ram_dout,
    output logic          bus_req,
    output logic          blcnten,
    output logic [12:0]   obj_AB,
    output logic [AW-1:0] buf_addr,
    output logic [7:0]    buf_din,
    output logic          buf_we,
    output logic          buf_sel,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, REQ, COPY, REL} state_t;
    state_t      st, st_nx;
    logic        pending, lvbl_l, trig, go, wr;
    logic [AW:0] cnt, cnt_m1;

    assign trig = lvbl_l & ~LVBL;
    assign go   = (st == IDLE) && (st_nx == REQ);

    always_comb begin
        st_nx = st;
        case (st)
            IDLE:    st_nx = (trig && pending) ? REQ  : IDLE;
            REQ:     st_nx = bus_ack           ? COPY : REQ;
            COPY:    st_nx = cnt[AW]           ? REL  : COPY;
            default: st_nx = bus_ack           ? REL  : IDLE;
        endcase
    end

    // cnt only reaches 2^AW in COPY, so its top bit marks the final cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= IDLE;
            pending <= 1'b0;
            lvbl_l  <= 1'b1;
            cnt     <= '0;
            buf_sel <= 1'b0;
        end else if (cen) begin
            st      <= st_nx;
            pending <= OKOUT | (pending & ~go);
            lvbl_l  <= LVBL;
            cnt     <= (st == COPY && !cnt[AW]) ? cnt + (AW+1)'(1) : '0;
            buf_sel <= buf_sel ^ (st == REL && !bus_ack);
        end
    end

    // RAM data lags the address by one cen, so byte cnt-1 is written at cnt
    assign cnt_m1   = cnt - (AW+1)'(1);
    assign wr       = (st == COPY) && (cnt != '0);
    assign buf_we   = cen & wr;
    assign buf_addr = wr ? cnt_m1[AW-1:0] : '0;
    assign buf_din  = wr ? ram_dout : 8'h00;
    assign obj_AB   = OBJ_BASE + 13'(cnt[AW-1:0]);
    assign bus_req  = (st == REQ) || (st == COPY);
    assign blcnten  = (st == COPY);
    assign busy     = (st != IDLE);
endmodule

// File: tb/tb_jt1943_objdma.sv
// tb_jt1943_objdma: directed bench for the object DMA, with a second instance exercising address wrap.
module tb_jt1943_objdma;
    logic        clk, rst_n, cen, LVBL, OKOUT, bus_ack;
    logic [7:0]  rd0, rd1;
    logic        bus_req0, blcnten0, buf_we0, buf_sel0, busy0;
    logic        bus_req1, blcnten1, buf_we1, buf_sel1, busy1;
    logic [12:0] ab0, ab1, a0, a1, pab;
    logic [8:0]  addr0, addr1;
    logic [7:0]  din0, din1;
    logic        c;
    int          checks, fails, w0, w1, wraps;

    jt1943_objdma u0 (
        .clk(clk), .rst_n(rst_n), .cen(cen), .LVBL(LVBL), .OKOUT(OKOUT), .bus_ack(bus_ack),
        .ram_dout(rd0), .bus_req(bus_req0), .blcnten(blcnten0), .obj_AB(ab0), .buf_addr(addr0),
        .buf_din(din0), .buf_we(buf_we0), .buf_sel(buf_sel0), .busy(busy0)
    );

    jt1943_objdma #(.AW(9), .OBJ_BASE(13'h1F80)) u1 (
        .clk(clk), .rst_n(rst_n), .cen(cen), .LVBL(LVBL), .OKOUT(OKOUT), .bus_ack(bus_ack),
        .ram_dout(rd1), .bus_req(bus_req1), .blcnten(blcnten1), .obj_AB(ab1), .buf_addr(addr1),
        .buf_din(din1), .buf_we(buf_we1), .buf_sel(buf_sel1), .busy(busy1)
    );

    function automatic logic [7:0] ram_f(input logic [12:0] a);
        logic [12:0] d;
        d = a - 13'h1000;
        return d[7:0] ^ 8'h5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        do @(posedge clk); while (cen !== 1'b1);
        #1;
    endtask

    task automatic wait_copy(input int exp_len, input logic exp_sel);
        int n = 0;
        while (blcnten0 && n < 600) begin
            tick();
            n++;
        end
        chk("copy_len", n, exp_len);
        chk("req_drop", bus_req0, 1'b0);
        chk("rel_busy", busy0, 1'b1);
        chk("sel_hold", buf_sel0, exp_sel);
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cen = 1'b0;
    always @(posedge clk) begin
        #2 cen = ~cen;
    end

    always @(posedge clk) begin
        a0 = ab0;
        a1 = ab1;
        c  = cen;
        #1;
        if (c) begin
            rd0 = ram_f(a0);
            rd1 = ram_f(a1);
        end
    end

    always @(negedge clk) begin
        if (buf_we0) begin
            chk("we_cen0", cen, 1'b1);
            chk("addr0", addr0, w0);
            chk("din0", din0, ram_f(13'h1000 + 13'(w0)));
            w0++;
        end
        if (buf_we1) begin
            chk("addr1", addr1, w1);
            chk("din1", din1, ram_f(13'h1F80 + 13'(w1)));
            w1++;
        end
        if (blcnten1) begin
            if (pab == 13'h1FFF && ab1 == 13'h0000) wraps++;
            pab = ab1;
        end
    end

    initial begin
        checks = 0; fails = 0; w0 = 0; w1 = 0; wraps = 0; pab = 13'h0;
        rd0 = 8'h00; rd1 = 8'h00;
        rst_n = 1'b0; LVBL = 1'b1; OKOUT = 1'b0; bus_ack = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_req", bus_req0, 1'b0);
        chk("rst_blc", blcnten0, 1'b0);
        chk("rst_ab", ab0, 13'h1000);
        chk("rst_we", buf_we0, 1'b0);
        chk("rst_addr", addr0, 9'd0);
        chk("rst_din", din0, 8'h00);
        chk("rst_sel", buf_sel0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        rst_n = 1'b1;
        tick(); tick();
        LVBL = 1'b0;
        tick(); tick();
        chk("no_ok_req", bus_req0, 1'b0);
        chk("no_ok_busy", busy0, 1'b0);
        LVBL = 1'b1;
        tick();
        // copy 1: normal, grant 3 cen after request
        w0 = 0; w1 = 0;
        OKOUT = 1'b1; tick(); OKOUT = 1'b0;
        LVBL = 1'b0; tick();
        chk("trig_req", bus_req0, 1'b1);
        chk("req_blc", blcnten0, 1'b0);
        repeat (3) tick();
        bus_ack = 1'b1; tick();
        chk("copy_blc", blcnten0, 1'b1);
        chk("copy_ab0", ab0, 13'h1000);
        chk("copy_ab1", ab1, 13'h1F80);
        wait_copy(513, 1'b0);
        chk("c1_w0", w0, 512);
        chk("c1_w1", w1, 512);
        chk("c1_wrap", wraps, 1);
        bus_ack = 1'b0; tick();
        chk("c1_sel0", buf_sel0, 1'b1);
        chk("c1_sel1", buf_sel1, 1'b1);
        chk("c1_idle", busy0, 1'b0);
        // copy 2: slow grant, LVBL rise and late OKOUT mid-copy
        LVBL = 1'b1; tick();
        w0 = 0; w1 = 0;
        OKOUT = 1'b1; tick(); OKOUT = 1'b0;
        LVBL = 1'b0; tick();
        repeat (100) tick();
        chk("slow_req", bus_req0, 1'b1);
        chk("slow_blc", blcnten0, 1'b0);
        chk("slow_we", w0, 0);
        bus_ack = 1'b1; tick();
        repeat (200) tick();
        LVBL = 1'b1; OKOUT = 1'b1; tick(); OKOUT = 1'b0;
        wait_copy(312, 1'b1);
        chk("c2_w0", w0, 512);
        chk("c2_w1", w1, 512);
        bus_ack = 1'b0; tick();
        chk("c2_sel", buf_sel0, 1'b0);
        // copy 3: started by the late OKOUT, aborted by reset at cnt=300
        w0 = 0; w1 = 0;
        LVBL = 1'b0; tick();
        chk("late_req", bus_req0, 1'b1);
        bus_ack = 1'b1; tick();
        repeat (300) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_req", bus_req0, 1'b0);
        chk("ar_blc", blcnten0, 1'b0);
        chk("ar_busy", busy0, 1'b0);
        chk("ar_sel", buf_sel0, 1'b0);
        chk("ar_ab", ab0, 13'h1000);
        chk("ar_w0", w0, 299);
        #5 rst_n = 1'b1; bus_ack = 1'b0; LVBL = 1'b1;
        tick(); tick();
        chk("ar_idle", bus_req0, 1'b0);
        // copy 4: full re-copy from byte 0
        w0 = 0; w1 = 0;
        OKOUT = 1'b1; tick(); OKOUT = 1'b0;
        LVBL = 1'b0; tick();
        chk("c4_req", bus_req0, 1'b1);
        bus_ack = 1'b1; tick();
        chk("c4_ab", ab0, 13'h1000);
        wait_copy(513, 1'b0);
        chk("c4_w0", w0, 512);
        chk("c4_w1", w1, 512);
        bus_ack = 1'b0; tick();
        chk("c4_sel", buf_sel0, 1'b1);
        chk("wraps", wraps, 4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/jt1943_objdma.md
# jt1943_objdma

Object DMA controller for the 1943 main board. Once per frame, and only after the main CPU has pulsed OKOUT, it requests the main CPU bus and copies the object attribute table out of the main work RAM into a double-buffered object line store. The block drives bus_req/blcnten/obj_AB into the main CPU block and consumes the RAM read data (ram_dout) that the main CPU block returns.

## Interface
- AW, 9, log2 of bytes copied per frame (512 = 128 objects × 4 bytes)
- OBJ_BASE, 13'h1000, first work-RAM offset of the object table (13-bit, within obj_AB space)
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- cen  in  1  clock enable, tied to main CPU cen6; all state advances only when cen=1
- LVBL  in  1  vertical blank, active-low
- OKOUT  in  1  CPU write strobe meaning "object table ready"; level, may be held several cen cycles
- bus_ack  in  1  CPU bus granted (inverse of BUSAK_n)
- ram_dout  in  8  work RAM read data; valid on the cen after obj_AB is presented
- bus_req  out  1  bus request to CPU
- blcnten  out  1  high while obj_AB owns the RAM address bus
- obj_AB  out  13  RAM address during copy
- buf_addr  out  AW  object store write address
- buf_din  out  8  object store write data
- buf_we  out  1  object store write strobe (one clk wide, coincident with cen)
- buf_sel  out  1  bank being written; the video side reads ~buf_sel
- busy  out  1  high in any state other than IDLE

## Operation
- pending flag: set on any cen with OKOUT=1 (level); cleared on entry to REQ. OKOUT arriving while the FSM is busy sets pending for the next frame; multiple OKOUTs collapse to one.
- Vblank start detect: LVBL sampled on cen; trigger = previous sample 1 and current sample 0.
- FSM states:
  - IDLE -> REQ on trigger && pending.
  - REQ: bus_req=1 -> COPY when bus_ack=1 (sampled on cen); no timeout.
  - COPY: blcnten=1, bus_req=1, 10-bit counter cnt runs 0..2^AW.
    - obj_AB = OBJ_BASE + cnt[AW-1:0], 13-bit wrap.
    - For cnt >= 1: buf_we=1, buf_addr = cnt-1, buf_din = ram_dout.
    - Leave to REL after the cen on which cnt = 2^AW.
  - REL: blcnten=0, bus_req=0; wait bus_ack=0 -> IDLE; buf_sel toggles on that transition.
- LVBL rising during COPY does not abort; the copy always completes.
- A trigger while the FSM is not in IDLE is ignored.
- The block never writes RAM: RAM write enable is suppressed by blcnten in the CPU block.

## Timing
- Reset values:
  - bus_req=0, blcnten=0, obj_AB=OBJ_BASE, buf_we=0, buf_addr=0, buf_din=0, buf_sel=0, busy=0.
  - pending=0, LVBL sample=1, cnt=0.
- Async reset mid-copy: all outputs return to their reset values immediately (bus released); the partial bank is not toggled.
- Trigger -> bus_req: 1 cen.
- bus_ack -> first obj_AB/blcnten: 1 cen.
- COPY length: 2^AW+1 cen cycles (513 at default); first buf_we 1 cen after COPY entry; last buf_we at buf_addr=2^AW-1.
- bus_req drops on the cen after the last write.
- buf_we is gated with cen, so it is high for exactly one clk per byte.

## Test plan
- Reset then idle: rst_n low mid-frame -> all outputs at reset values; LVBL falls with no OKOUT -> bus_req stays 0.
- Normal copy: RAM[0x1000+i]=i^8'h5A, OKOUT pulse, LVBL falls, bus_ack asserted 3 cen later -> 512 buf_we pulses, buf_addr 0..511, buf_din = i^8'h5A, buf_sel 0->1 after bus_ack drops.
- Late OKOUT: OKOUT during COPY -> current copy unaffected, next LVBL fall starts a new copy, buf_sel returns to 0 afterwards.
- Slow grant: bus_ack held low for 100 cen -> bus_req held, blcnten=0, no buf_we until grant.
- LVBL rises at cnt=200 -> copy continues to 512 bytes.
- Async reset at cnt=300 -> bus_req/blcnten drop the same clk, buf_sel unchanged; a later trigger re-copies from byte 0.
- OBJ_BASE=13'h1F80 -> obj_AB wraps from 13'h1FFF to 13'h0000; 512 bytes still written.
